uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8N1, DATA_READY/BUSY/DONE interface) among NUM_REQ byte requesters.
- Round-robin arbitration at packet granularity: the granted requester keeps the transmitter until it sends a byte flagged LAST.
- Issues one byte per frame and waits for the transmitter's DONE pulse before issuing the next.
- A watchdog recovers the block if DONE never arrives.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter and related schedulers.
package uart_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Default sizing
    localparam int NUM_REQ_DEFAULT        = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    // 8N1 frame: start + 8 data + stop
    localparam int FRAME_BITS = 10;
    localparam int DATA_WIDTH = 8;

    // Advance a pointer by one, wrapping with an explicit compare so that
    // non-power-of-two requester counts wrap correctly.
    function automatic int wrap_inc(input int ptr, input int n);
        int res;
        if (ptr >= n - 1) begin
            res = 0;
        end else begin
            res = ptr + 1;
        end
        return res;
    endfunction

    // Add an offset (< n) to a base index (< n) modulo n without a divider.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: the first asserted request found
// when searching upward from i_start (wrapping) wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int  NUM_REQ  = NUM_REQ_DEFAULT,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_start,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grant_id,
    output logic                o_any
);

    logic [ID_WIDTH-1:0] cand_s;
    logic                hit_s;

    // Search from the farthest offset down to offset 0 so the closest hit to
    // the start index is the one left standing.
    always_comb begin
        o_grant    = {NUM_REQ{1'b0}};
        o_grant_id = {ID_WIDTH{1'b0}};
        o_any      = 1'b0;
        cand_s     = {ID_WIDTH{1'b0}};
        hit_s      = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s     = ID_WIDTH'(wrap_add(int'(i_start), i, NUM_REQ));
            hit_s      = i_req[cand_s];
            o_grant    = hit_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cand_s) : o_grant;
            o_grant_id = hit_s ? cand_s : o_grant_id;
            o_any      = o_any | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmitter among NUM_REQ byte requesters with
// packet-granular round-robin arbitration and a DONE watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ        = NUM_REQ_DEFAULT,
    parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                           i_CLK,
    input  logic                           i_RESET,
    input  logic [NUM_REQ-1:0]             i_req_VALID,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  i_req_DATA,
    input  logic [NUM_REQ-1:0]             i_req_LAST,
    output logic [NUM_REQ-1:0]             o_req_READY,
    output logic                           o_tx_DATA_READY,
    output logic [DATA_WIDTH-1:0]          o_tx_DATA,
    input  logic                           i_tx_BUSY,
    input  logic                           i_tx_DONE,
    output logic [ID_WIDTH-1:0]            o_GRANT_ID,
    output logic                           o_LOCKED,
    output logic                           o_BUSY,
    output logic                           o_ERROR
);

    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES);

    // Registered state
    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    last_q, last_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic                    locked_q, locked_d;
    logic                    dr_q, dr_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [WD_WIDTH-1:0]     wd_q, wd_d;

    // Arbitration signals
    logic [NUM_REQ-1:0]      owner_mask_s;
    logic [NUM_REQ-1:0]      eligible_s;
    logic [ID_WIDTH-1:0]     start_s;
    logic [NUM_REQ-1:0]      pick_grant_s;
    logic [ID_WIDTH-1:0]     pick_id_s;
    logic                    pick_any_s;
    logic [DATA_WIDTH-1:0]   pick_data_s;
    logic                    pick_last_s;
    logic                    accept_s;
    logic [NUM_REQ-1:0]      ready_s;

    // While a packet is in progress only its owner may be chosen; otherwise
    // the search starts just past the previous winner.
    always_comb begin
        owner_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
        if (locked_q) begin
            eligible_s = i_req_VALID & owner_mask_s;
            start_s    = grant_q;
        end else begin
            eligible_s = i_req_VALID;
            start_s    = ID_WIDTH'(wrap_inc(int'(grant_q), NUM_REQ));
        end
    end

    uart_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .i_req      (eligible_s),
        .i_start    (start_s),
        .o_grant    (pick_grant_s),
        .o_grant_id (pick_id_s),
        .o_any      (pick_any_s)
    );

    // Select the winner's byte and LAST flag through a one-hot AND-OR mux.
    always_comb begin
        pick_data_s = {DATA_WIDTH{1'b0}};
        pick_last_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_data_s = pick_data_s |
                          (i_req_DATA[DATA_WIDTH*k +: DATA_WIDTH] & {DATA_WIDTH{pick_grant_s[k]}});
            pick_last_s = pick_last_s | (i_req_LAST[k] & pick_grant_s[k]);
        end
    end

    // A byte is accepted only in IDLE with the transmitter idle; READY is the
    // picker's one-hot grant in that cycle and zero otherwise.
    always_comb begin
        accept_s = (state_q == ST_IDLE) && pick_any_s && !i_tx_BUSY && !i_RESET;
        if (accept_s) begin
            ready_s = pick_grant_s;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic for the issue/wait sequence and the watchdog.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        wd_d      = wd_q;
        dr_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    tx_data_d = pick_data_s;
                    last_d    = pick_last_s;
                    grant_d   = pick_id_s;
                    locked_d  = 1'b1;
                    dr_d      = 1'b1;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_d    = {WD_WIDTH{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_DONE) begin
                    // DONE takes precedence over a coincident timeout.
                    if (last_q) begin
                        locked_d = 1'b0;
                    end else begin
                        locked_d = locked_q;
                    end
                    state_d = ST_IDLE;
                end else if (wd_q == WD_WIDTH'(TIMEOUT_CYCLES - 2)) begin
                    // Counter is about to reach TIMEOUT_CYCLES-1: abandon
                    // the packet so the error pulse lands TIMEOUT_CYCLES
                    // after the issue pulse.
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    wd_d = wd_q + {{(WD_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                locked_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control FSM and registered outputs; a reset drops any packet in flight.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q   <= ST_IDLE;
            tx_data_q <= {DATA_WIDTH{1'b0}};
            last_q    <= 1'b0;
            grant_q   <= ID_WIDTH'(NUM_REQ - 1);
            locked_q  <= 1'b0;
            dr_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            wd_q      <= {WD_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            dr_q      <= dr_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            wd_q      <= wd_d;
        end
    end

    assign o_req_READY     = ready_s;
    assign o_tx_DATA_READY = dr_q;
    assign o_tx_DATA       = tx_data_q;
    assign o_GRANT_ID      = grant_q;
    assign o_LOCKED        = locked_q;
    assign o_BUSY          = busy_q;
    assign o_ERROR         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters).
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int T   = 4096;
    localparam int LAT = 2170;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ready;
    logic        dr;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        locked;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_CLK           (clk),
        .i_RESET         (rst),
        .i_req_VALID     (req_valid),
        .i_req_DATA      (req_data),
        .i_req_LAST      (req_last),
        .o_req_READY     (ready),
        .o_tx_DATA_READY (dr),
        .o_tx_DATA       (tx_data),
        .i_tx_BUSY       (tx_busy),
        .i_tx_DONE       (tx_done),
        .o_GRANT_ID      (grant_id),
        .o_LOCKED        (locked),
        .o_BUSY          (busy),
        .o_ERROR         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic l);
        req_valid[k[1:0]] = 1'b1;
        req_data[{k[1:0], 3'b000} +: 8] = d;
        req_last[k[1:0]] = l;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  ready,    32'd0);
        check({tag, "_dr"},     dr,       32'd0);
        check({tag, "_data"},   tx_data,  32'd0);
        check({tag, "_grant"},  grant_id, 32'd3);
        check({tag, "_locked"}, locked,   32'd0);
        check({tag, "_busy"},   busy,     32'd0);
        check({tag, "_err"},    err,      32'd0);
    endtask

    // Entered in IDLE just after an edge with inputs set. Checks the accept,
    // the issue pulse one cycle later, frame stability, then returns DONE
    // d cycles after the pulse and checks the post-DONE state.
    task automatic do_byte(input string tag, input int idx, input logic [7:0] b,
                           input logic exp_locked, input int d, input bit keep);
        logic       stable_bad;
        logic [3:0] exp_ready;
        #1;
        exp_ready = 4'b0001 << idx;
        check({tag, "_ready"}, ready, exp_ready);
        tick();
        if (!keep) req_valid[idx[1:0]] = 1'b0;
        check({tag, "_pulse"},     dr,       32'd1);
        check({tag, "_txdata"},    tx_data,  b);
        check({tag, "_grant"},     grant_id, idx);
        check({tag, "_lock_iss"},  locked,   32'd1);
        check({tag, "_ready_iss"}, ready,    32'd0);
        check({tag, "_err_iss"},   err,      32'd0);
        stable_bad = 1'b0;
        tick();
        for (int i = 1; i < d; i++) begin
            if (dr !== 1'b0 || tx_data !== b || ready !== 4'b0000) stable_bad = 1'b1;
            tick();
        end
        if (dr !== 1'b0 || tx_data !== b) stable_bad = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_stable"},    stable_bad, 32'd0);
        check({tag, "_lock_done"}, locked,     exp_locked);
        check({tag, "_busy_done"}, busy,       32'd0);
        check({tag, "_err_done"},  err,        32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        req_last  = 4'b0000;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;

        // Reset state, applied before any clock edge.
        #1;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_rel_grant", grant_id, 32'd3);

        // All four valid with LAST: served 0,1,2,3.
        set_req(0, 8'h10, 1'b1);
        set_req(1, 8'h21, 1'b1);
        set_req(2, 8'h32, 1'b1);
        set_req(3, 8'h43, 1'b1);
        do_byte("s1b0", 0, 8'h10, 1'b0, 5, 1'b0);
        do_byte("s1b1", 1, 8'h21, 1'b0, 5, 1'b0);
        do_byte("s1b2", 2, 8'h32, 1'b0, 5, 1'b0);
        do_byte("s1b3", 3, 8'h43, 1'b0, 5, 1'b0);

        // Requester 2 packet A1..A3 holds the grant against requester 0.
        set_req(2, 8'hA1, 1'b0);
        do_byte("s2a1", 2, 8'hA1, 1'b1, 4, 1'b0);
        set_req(0, 8'h77, 1'b1);
        #1;
        check("s2_blocked0", ready, 32'd0);
        tick();
        check("s2_blocked1", ready, 32'd0);
        check("s2_locked",   locked, 32'd1);
        set_req(2, 8'hA2, 1'b0);
        do_byte("s2a2", 2, 8'hA2, 1'b1, 4, 1'b0);
        set_req(2, 8'hA3, 1'b1);
        do_byte("s2a3", 2, 8'hA3, 1'b0, 4, 1'b0);
        do_byte("s2r0", 0, 8'h77, 1'b0, 4, 1'b0);

        // Watchdog: DONE never returned for requester 1.
        set_req(1, 8'h5A, 1'b0);
        set_req(2, 8'h66, 1'b1);
        #1;
        check("s3_ready", ready, 32'h2);
        tick();
        req_valid[1] = 1'b0;
        check("s3_pulse",  dr,      32'd1);
        check("s3_txdata", tx_data, 32'h5A);
        check("s3_locked", locked,  32'd1);
        repeat (T - 1) tick();
        check("s3_err_early", err,  32'd0);
        check("s3_busy_wait", busy, 32'd1);
        tick();
        check("s3_err_pulse", err,    32'd1);
        check("s3_unlocked",  locked, 32'd0);
        check("s3_idle",      busy,   32'd0);
        do_byte("s3nx", 2, 8'h66, 1'b0, 3, 1'b0);

        // Asynchronous reset in the middle of a locked frame.
        set_req(3, 8'h99, 1'b0);
        set_req(0, 8'h11, 1'b1);
        #1;
        check("s4_ready", ready, 32'h8);
        tick();
        req_valid[3] = 1'b0;
        tick();
        tick();
        check("s4_busy_pre",   busy,   32'd1);
        check("s4_locked_pre", locked, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("s4rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_byte("s4nx", 0, 8'h11, 1'b0, 4, 1'b0);

        // Transmitter busy blocks accepts; spurious DONE in IDLE is ignored.
        set_req(1, 8'h3C, 1'b1);
        tx_busy = 1'b1;
        #1;
        check("s5_ready0", ready, 32'd0);
        tick();
        check("s5_ready1", ready, 32'd0);
        check("s5_dr1",    dr,    32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("s5_busy",   busy,     32'd0);
        check("s5_locked", locked,   32'd0);
        check("s5_grant",  grant_id, 32'd0);
        check("s5_dr2",    dr,       32'd0);
        check("s5_ready2", ready,    32'd0);
        tick();
        tx_busy = 1'b0;
        do_byte("s5go", 1, 8'h3C, 1'b0, 3, 1'b0);

        // Single requester streaming with realistic frame latency.
        set_req(2, 8'h55, 1'b1);
        do_byte("s6b0", 2, 8'h55, 1'b0, LAT, 1'b1);
        do_byte("s6b1", 2, 8'h55, 1'b0, LAT, 1'b1);
        do_byte("s6b2", 2, 8'h55, 1'b0, LAT, 1'b1);
        req_valid[2] = 1'b0;
        tick();
        check("s6_idle_end", busy, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
